// File: rtl/zpu_io_uart_pkg.sv
// ============================================================================
// Module      : zpu_io_uart_pkg
// Description : Shared widths, register map and FSM state types for the
//               ZPU memory-mapped UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zpu_io_uart_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int MAX_ADDR_BIT_IO = 27;
    localparam int ADDR_W          = MAX_ADDR_BIT_IO + 1;

    localparam logic [ADDR_W-1:0] DEF_TX_ADDR = 28'h80a000c;
    localparam logic [ADDR_W-1:0] DEF_RX_ADDR = 28'h80a0008;

    // Status bit positions shared with software
    localparam int TX_IDLE_BIT  = 8;
    localparam int RX_VALID_BIT = 8;
    localparam int RX_OVR_BIT   = 9;
    localparam int RX_FERR_BIT  = 10;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/zpu_uart_rx.sv
// ============================================================================
// Module      : zpu_uart_rx
// Description : 8N1 receiver: input synchroniser, mid-bit sampling FSM and a
//               holding register with valid/overrun/framing-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zpu_uart_rx
    import zpu_io_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       rxd,
    input  logic       clear,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ovr,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;
    logic            load, set_ferr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        load     = 1'b0;
        set_ferr = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync2_q) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = R_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = R_IDLE;
                    load     = sync2_q;
                    set_ferr = !sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = R_IDLE;
        endcase

        // A read coinciding with a new byte consumes the old one, so no overrun
        data_d  = load ? shift_q : data_q;
        valid_d = load | (valid_q & ~clear);
        ovr_d   = (load & valid_q & ~clear) | (ovr_q & ~clear);
        ferr_d  = set_ferr | (ferr_q & ~clear);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ovr   = ovr_q;
    assign rx_ferr  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/zpu_io_uart.sv
// ============================================================================
// Module      : zpu_io_uart
// Description : ZPU IO-mapped UART: register decode, read handshake and the
//               8N1 transmitter; the receiver lives in zpu_uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zpu_io_uart
    import zpu_io_uart_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 868,
    parameter logic [ADDR_W-1:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [ADDR_W-1:0] RX_ADDR      = DEF_RX_ADDR
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [ADDR_W-1:0]    io_addr,
    input  logic                 io_writeEnable,
    input  logic                 io_readEnable,
    input  logic [WORD_SIZE-1:0] io_write,
    output logic [WORD_SIZE-1:0] io_read,
    output logic                 io_busy,
    output logic                 io_ready,
    output logic                 txd,
    input  logic                 rxd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d;
    logic [WORD_SIZE-1:0] read_q, read_d;
    logic                 ready_q, ready_d;

    logic       tx_idle, wr_tx, rd_any, rx_clear;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ovr, rx_ferr;
    logic       unused_write_bits;

    assign unused_write_bits = ^io_write[WORD_SIZE-1:8];

    zpu_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .areset   (areset),
        .rxd      (rxd),
        .clear    (rx_clear),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ovr   (rx_ovr),
        .rx_ferr  (rx_ferr)
    );

    assign tx_idle  = (tx_state_q == T_IDLE);
    assign wr_tx    = io_writeEnable && (io_addr == TX_ADDR);
    // A write in the same cycle as a read takes priority; the read yields 0
    assign rd_any   = io_readEnable && !io_writeEnable;
    assign rx_clear = rd_any && (io_addr == RX_ADDR);
    assign io_busy  = io_readEnable;

    always_comb begin
        read_d  = '0;
        ready_d = io_readEnable;
        if (rd_any) begin
            if (io_addr == TX_ADDR) begin
                read_d[TX_IDLE_BIT] = tx_idle;
            end else if (io_addr == RX_ADDR) begin
                read_d[7:0]          = rx_data;
                read_d[RX_VALID_BIT] = rx_valid;
                read_d[RX_OVR_BIT]   = rx_ovr;
                read_d[RX_FERR_BIT]  = rx_ferr;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            T_IDLE: begin
                txd_d = 1'b1;
                if (wr_tx) begin
                    tx_shift_d = io_write[7:0];
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = T_START;
                end
            end
            T_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = T_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            T_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = T_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            T_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = T_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            read_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            read_q     <= read_d;
            ready_q    <= ready_d;
        end
    end

    assign txd      = txd_q;
    assign io_read  = read_q;
    assign io_ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_zpu_io_uart.sv
// ============================================================================
// Module      : tb_zpu_io_uart
// Description : Directed self-checking bench for zpu_io_uart at 4 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zpu_io_uart;
    import zpu_io_uart_pkg::*;

    localparam int CPB = 4;
    localparam logic [ADDR_W-1:0] A_TX  = 28'h80a000c;
    localparam logic [ADDR_W-1:0] A_RX  = 28'h80a0008;
    localparam logic [ADDR_W-1:0] A_BAD = 28'h80a0010;

    logic              clk = 1'b0;
    logic              areset;
    logic [ADDR_W-1:0] io_addr;
    logic              io_writeEnable;
    logic              io_readEnable;
    logic [31:0]       io_write;
    logic [31:0]       io_read;
    logic              io_busy;
    logic              io_ready;
    logic              txd;
    logic              rxd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zpu_io_uart #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .io_addr        (io_addr),
        .io_writeEnable (io_writeEnable),
        .io_readEnable  (io_readEnable),
        .io_write       (io_write),
        .io_read        (io_read),
        .io_busy        (io_busy),
        .io_ready       (io_ready),
        .txd            (txd),
        .rxd            (rxd)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Two-cycle read: busy in the strobe cycle, ready with data the next
    task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data);
        io_addr       = addr;
        io_readEnable = 1'b1;
        #1;
        check("busy_during_read", {31'b0, io_busy}, 32'h1);
        step();
        io_readEnable = 1'b0;
        check("ready_after_read", {31'b0, io_ready}, 32'h1);
        data = io_read;
        #1;
        check("busy_released", {31'b0, io_busy}, 32'h0);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [7:0] d);
        io_addr        = addr;
        io_write       = {24'hABCDEF, d};
        io_writeEnable = 1'b1;
        step();
        io_writeEnable = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            step(CPB);
        end
        rxd = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame41;
        frame41 = {1'b1, 8'h41, 1'b0};

        areset = 1'b1; io_addr = '0; io_writeEnable = 1'b0; io_readEnable = 1'b0;
        io_write = '0; rxd = 1'b1;
        step(3);
        check("reset_txd",   {31'b0, txd},      32'h1);
        check("reset_ready", {31'b0, io_ready}, 32'h0);
        check("reset_busy",  {31'b0, io_busy},  32'h0);
        check("reset_read",  io_read,           32'h0);
        areset = 1'b0;
        step(2);

        // Single TX frame of 'h41, checked mid-bit
        do_write(A_TX, 8'h41);
        check("tx_start_edge", {31'b0, txd}, 32'h0);
        step(2);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx1_bit%0d", i), {31'b0, txd}, {31'b0, frame41[i]});
            step(CPB);
        end
        do_read(A_TX, rd);
        check("tx_status_idle", rd, 32'h100);
        step(2);

        // Second write while busy is dropped; status reads 0 mid-frame
        do_write(A_TX, 8'h41);
        step();
        do_write(A_TX, 8'h42);
        do_read(A_TX, rd);
        check("tx_status_busy", rd, 32'h0);
        step(3);
        for (int i = 1; i < 10; i++) begin
            check($sformatf("tx2_bit%0d", i), {31'b0, txd}, {31'b0, frame41[i]});
            step(CPB);
        end
        step(4);
        check("tx2_idle_line", {31'b0, txd}, 32'h1);

        // RX of 'h5A, then a second read sees the cleared flag
        send_frame(8'h5A, 1'b1);
        step(4);
        do_read(A_RX, rd);
        check("rx_5a_first", rd, 32'h15A);
        step();
        check("ready_one_cycle", {31'b0, io_ready}, 32'h0);
        do_read(A_RX, rd);
        check("rx_5a_second", rd, 32'h05A);
        step(2);

        // Overrun: two bytes without a read
        send_frame(8'h11, 1'b1);
        step(4);
        send_frame(8'h22, 1'b1);
        step(4);
        do_read(A_RX, rd);
        check("rx_overrun", rd, 32'h322);
        step(2);

        // Reset in the middle of a TX frame
        do_write(A_TX, 8'h00);
        step(10);
        check("tx_mid_frame_low", {31'b0, txd}, 32'h0);
        areset = 1'b1;
        step();
        check("reset_mid_txd", {31'b0, txd}, 32'h1);
        areset = 1'b0;
        do_read(A_TX, rd);
        check("reset_mid_idle", rd, 32'h100);
        step(2);

        // Framing error, then a glitch that must not produce a byte
        send_frame(8'h00, 1'b0);
        step(4);
        do_read(A_RX, rd);
        check("rx_ferr", rd, 32'h400);
        step(2);
        rxd = 1'b0;
        step();
        rxd = 1'b1;
        step(3 * CPB);
        do_read(A_RX, rd);
        check("rx_glitch", rd, 32'h0);
        step();

        do_read(A_BAD, rd);
        check("bad_addr_read", rd, 32'h0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
